// File: rtl/multibyte_add_ctrl_if.sv
// multibyte_add_ctrl_if
//   Request/result bundle for the byte-serial add/subtract controller.
//   master : requester side, drives start/sub/cin/a/b and observes the result.
//   slave  : controller side, samples the request and drives busy/done/sum/cout/ovf.
//   Ports (all W = 8*NBYTES wide where not 1 bit):
//     start, sub, cin, a, b   request and operands
//     busy, done              progress / one-cycle completion pulse
//     sum, cout, ovf          W-bit result, final carry, signed overflow
interface multibyte_add_ctrl_if #(
  parameter int NBYTES = 4
);
  localparam int W = 8 * NBYTES;

  logic         start;
  logic         sub;
  logic         cin;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  modport master (
    output start, sub, cin, a, b,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, cin, a, b,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/multibyte_add_ctrl.sv
// multibyte_add_ctrl
//   Performs an NBYTES-wide add or subtract by running one shared 8-bit
//   ripple-carry adder (fadder8bit) over the operands one byte per clock,
//   least-significant byte first, carrying between bytes in a register.
//   Ports:
//     clk      rising-edge clock
//     reset_n  synchronous active-low reset
//     bus      multibyte_add_ctrl_if.slave (start/sub/cin/a/b in,
//              busy/done/sum/cout/ovf out, all outputs registered)

// 8-bit ripple-carry full adder.
module fadder8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);
  logic [8:0] carry;

  assign carry[0] = cin;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_fa
      assign sum[gi]       = a[gi] ^ b[gi] ^ carry[gi];
      assign carry[gi + 1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
    end
  endgenerate

  assign cout = carry[8];
endmodule

module multibyte_add_ctrl #(
  parameter int NBYTES = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  multibyte_add_ctrl_if.slave  bus
);
  localparam int W    = 8 * NBYTES;
  localparam int IDXW = $clog2(NBYTES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_reg;
  logic [W-1:0]      a_reg;
  logic [W-1:0]      b_reg;
  logic              sub_reg;
  logic              carry_reg;
  logic [IDXW-1:0]   idx_reg;
  logic [W-1:0]      sum_reg;
  logic              busy_reg;
  logic              done_reg;
  logic              cout_reg;
  logic              ovf_reg;

  // Datapath around the single shared adder.
  logic [W-1:0]      b_eff;
  logic [IDXW+2:0]   slice_lsb;
  logic [7:0]        a_slice;
  logic [7:0]        b_slice;
  logic [7:0]        add_sum;
  logic              add_cout;
  logic              last_slice;
  logic              ovf_next;

  // Subtract is A + ~B + 1; the +1 comes from the carry register seeded at start.
  assign b_eff      = sub_reg ? ~b_reg : b_reg;
  assign slice_lsb  = {idx_reg, 3'b000};
  assign a_slice    = a_reg[slice_lsb +: 8];
  assign b_slice    = b_eff[slice_lsb +: 8];
  assign last_slice = (idx_reg == IDXW'(NBYTES - 1));

  // Overflow: operands agree in sign but the result's MSB (bit 7 of the top
  // slice, written this cycle) disagrees.
  assign ovf_next = (a_reg[W-1] == b_eff[W-1]) && (add_sum[7] != a_reg[W-1]);

  fadder8bit u_adder (
    .a    (a_slice),
    .b    (b_slice),
    .cin  (carry_reg),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      sub_reg   <= 1'b0;
      carry_reg <= 1'b0;
      idx_reg   <= '0;
      sum_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          done_reg <= 1'b0;
          if (bus.start) begin
            a_reg     <= bus.a;
            b_reg     <= bus.b;
            sub_reg   <= bus.sub;
            carry_reg <= bus.sub ? 1'b1 : bus.cin;
            idx_reg   <= '0;
            // Upper bytes read zero until their slice is written.
            sum_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= RUN;
          end else begin
            state_reg <= IDLE;
          end
        end

        RUN: begin
          sum_reg[slice_lsb +: 8] <= add_sum;
          carry_reg               <= add_cout;
          if (last_slice) begin
            // idx stays at NBYTES-1 rather than wrapping.
            cout_reg  <= add_cout;
            ovf_reg   <= ovf_next;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end

        default: begin
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_reg;
  assign bus.done = done_reg;
  assign bus.sum  = sum_reg;
  assign bus.cout = cout_reg;
  assign bus.ovf  = ovf_reg;
endmodule

// File: tb/tb_multibyte_add_ctrl.sv
// tb_multibyte_add_ctrl
//   Directed bench for multibyte_add_ctrl with NBYTES = 4. Each scenario task
//   drives its stimulus and compares outputs against hand-computed values.
module tb_multibyte_add_ctrl;
  logic clk;
  logic reset_n;
  int   errors;
  int   checks;

  multibyte_add_ctrl_if #(.NBYTES(4)) bus ();

  multibyte_add_ctrl #(.NBYTES(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Pulse start for one accepted edge, then wait (bounded) for done.
  // cyc = edges from the accepting edge to done (20 means timeout);
  // busy_bad counts cycles in between where busy was not high.
  task automatic run_op(input logic [31:0] av, input logic [31:0] bv,
                        input logic sv, input logic cv,
                        output int cyc, output int busy_bad);
    bus.a = av; bus.b = bv; bus.sub = sv; bus.cin = cv; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 0;
    busy_bad = 0;
    while (bus.done !== 1'b1 && cyc < 20) begin
      if (bus.busy !== 1'b1) busy_bad++;
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.start = 1'b1; bus.a = 32'h1234_5678; bus.b = 32'h1111_1111;
    bus.sub = 1'b0; bus.cin = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    checks++; if (bus.cout !== 1'b0) begin errors++; $display("FAIL reset_cout got=%b exp=0", bus.cout); end
    checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", bus.ovf); end
    checks++; if (bus.sum !== 32'h0) begin errors++; $display("FAIL reset_sum got=%h exp=00000000", bus.sum); end
    bus.start = 1'b0;
    reset_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_nostart got=%b exp=0", bus.busy); end
    $display("test_reset: done");
  endtask

  task automatic test_byte_carry();
    int cyc, bb;
    run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, cyc, bb);
    checks++; if (cyc !== 4) begin errors++; $display("FAIL carry_latency got=%0d exp=4", cyc); end
    checks++; if (bb !== 0) begin errors++; $display("FAIL carry_busy_low_cycles got=%0d exp=0", bb); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL carry_busy_at_done got=%b exp=0", bus.busy); end
    checks++; if (bus.sum !== 32'h0000_0100) begin errors++; $display("FAIL carry_sum got=%h exp=00000100", bus.sum); end
    checks++; if (bus.cout !== 1'b0) begin errors++; $display("FAIL carry_cout got=%b exp=0", bus.cout); end
    checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL carry_ovf got=%b exp=0", bus.ovf); end
    @(posedge clk); #1;
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL carry_done_pulse got=%b exp=0", bus.done); end
    checks++; if (bus.sum !== 32'h0000_0100) begin errors++; $display("FAIL carry_sum_hold got=%h exp=00000100", bus.sum); end
    $display("test_byte_carry: 000000FF+00000001 -> %h", bus.sum);
  endtask

  task automatic test_full_wrap();
    logic [31:0] av [2] = '{32'hFFFF_FFFF, 32'h7FFF_FFFF};
    logic [31:0] bv [2] = '{32'h0000_0001, 32'h0000_0000};
    logic        cv [2] = '{1'b0, 1'b1};
    logic [31:0] es [2] = '{32'h0000_0000, 32'h8000_0000};
    logic        ec [2] = '{1'b1, 1'b0};
    logic        eo [2] = '{1'b0, 1'b1};
    int cyc, bb;
    for (int i = 0; i < 2; i++) begin
      run_op(av[i], bv[i], 1'b0, cv[i], cyc, bb);
      checks++; if (cyc !== 4) begin errors++; $display("FAIL wrap%0d_latency got=%0d exp=4", i, cyc); end
      checks++; if (bus.sum !== es[i]) begin errors++; $display("FAIL wrap%0d_sum got=%h exp=%h", i, bus.sum, es[i]); end
      checks++; if (bus.cout !== ec[i]) begin errors++; $display("FAIL wrap%0d_cout got=%b exp=%b", i, bus.cout, ec[i]); end
      checks++; if (bus.ovf !== eo[i]) begin errors++; $display("FAIL wrap%0d_ovf got=%b exp=%b", i, bus.ovf, eo[i]); end
      $display("test_full_wrap: %h+%h+%b -> %h c=%b v=%b", av[i], bv[i], cv[i], bus.sum, bus.cout, bus.ovf);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_subtract();
    logic [31:0] av [2] = '{32'h0000_0005, 32'h8000_0000};
    logic [31:0] bv [2] = '{32'h0000_0007, 32'h0000_0001};
    logic [31:0] es [2] = '{32'hFFFF_FFFE, 32'h7FFF_FFFF};
    logic        ec [2] = '{1'b0, 1'b1};
    logic        eo [2] = '{1'b0, 1'b1};
    int cyc, bb;
    for (int i = 0; i < 2; i++) begin
      run_op(av[i], bv[i], 1'b1, 1'b1, cyc, bb);
      checks++; if (cyc !== 4) begin errors++; $display("FAIL sub%0d_latency got=%0d exp=4", i, cyc); end
      checks++; if (bus.sum !== es[i]) begin errors++; $display("FAIL sub%0d_sum got=%h exp=%h", i, bus.sum, es[i]); end
      checks++; if (bus.cout !== ec[i]) begin errors++; $display("FAIL sub%0d_cout got=%b exp=%b", i, bus.cout, ec[i]); end
      checks++; if (bus.ovf !== eo[i]) begin errors++; $display("FAIL sub%0d_ovf got=%b exp=%b", i, bus.ovf, eo[i]); end
      $display("test_subtract: %h-%h -> %h c=%b v=%b", av[i], bv[i], bus.sum, bus.cout, bus.ovf);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_run();
    int cyc, bb, done_seen, busy_seen;
    // Leaves cout = ovf = 1 from the previous subtract in place.
    bus.a = 32'h1234_5678; bus.b = 32'h1111_1111; bus.sub = 1'b0; bus.cin = 1'b0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL midrst_done got=%b exp=0", bus.done); end
    checks++; if (bus.sum !== 32'h0) begin errors++; $display("FAIL midrst_sum got=%h exp=00000000", bus.sum); end
    checks++; if (bus.cout !== 1'b0) begin errors++; $display("FAIL midrst_cout got=%b exp=0", bus.cout); end
    checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL midrst_ovf got=%b exp=0", bus.ovf); end
    done_seen = 0;
    busy_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) done_seen++;
      if (bus.busy === 1'b1) busy_seen++;
    end
    checks++; if (done_seen !== 0) begin errors++; $display("FAIL midrst_no_done got=%0d exp=0", done_seen); end
    checks++; if (busy_seen !== 0) begin errors++; $display("FAIL midrst_idle got=%0d exp=0", busy_seen); end
    run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, cyc, bb);
    checks++; if (cyc !== 4) begin errors++; $display("FAIL midrst_next_latency got=%0d exp=4", cyc); end
    checks++; if (bus.sum !== 32'h2345_6789) begin errors++; $display("FAIL midrst_next_sum got=%h exp=23456789", bus.sum); end
    $display("test_reset_mid_run: recovered op -> %h", bus.sum);
    @(posedge clk); #1;
  endtask

  task automatic test_start_handling();
    int cyc;
    bus.a = 32'h1; bus.b = 32'h2; bus.sub = 1'b0; bus.cin = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    // Pulse during RUN must be ignored.
    bus.a = 32'h10; bus.b = 32'h20; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 2;
    while (bus.done !== 1'b1 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++; if (cyc !== 4) begin errors++; $display("FAIL start_ignored_latency got=%0d exp=4", cyc); end
    checks++; if (bus.sum !== 32'h3) begin errors++; $display("FAIL start_ignored_sum got=%h exp=00000003", bus.sum); end
    $display("test_start_handling: 1+2 with mid-run pulse -> %h", bus.sum);
    // Start held in the DONE cycle restarts immediately.
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_busy got=%b exp=1", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL b2b_done_clear got=%b exp=0", bus.done); end
    checks++; if (bus.sum !== 32'h0) begin errors++; $display("FAIL b2b_sum_cleared got=%h exp=00000000", bus.sum); end
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++; if (cyc !== 4) begin errors++; $display("FAIL b2b_latency got=%0d exp=4", cyc); end
    checks++; if (bus.sum !== 32'h30) begin errors++; $display("FAIL b2b_sum got=%h exp=00000030", bus.sum); end
    $display("test_start_handling: back-to-back 10+20 -> %h", bus.sum);
    @(posedge clk); #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset_n = 1'b0;
    bus.start = 1'b0; bus.sub = 1'b0; bus.cin = 1'b0;
    bus.a = '0; bus.b = '0;
    test_reset();
    test_byte_carry();
    test_full_wrap();
    test_subtract();
    test_reset_mid_run();
    test_start_handling();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
